// File: rtl/photon_pkg.sv
// Shared constants and types for the photon-counter history blocks.
// Holds the history/GRAM geometry, colours and the renderer state encoding.
package photon_pkg;

  localparam logic [23:0] HIST_BASE = 24'd384000;
  localparam int          HIST_LEN  = 600;
  localparam int          LCD_W     = 800;
  localparam int          LCD_H     = 480;
  localparam int          Y_SHIFT   = 0;

  localparam logic [9:0]  X_OFS     = 10'd100;
  localparam logic [9:0]  LAST_COL  = 10'(HIST_LEN - 1);
  localparam logic [8:0]  Y_MAX     = 9'(LCD_H - 1);

  localparam logic [15:0] FG_COLOR  = 16'hF800;
  localparam logic [15:0] BG_COLOR  = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CALC  = 3'd2,
    S_ERASE = 3'd3,
    S_DRAW  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // y*800 as shift-and-add; y < 480 so the product fits in 19 bits
  function automatic logic [23:0] row_base(input logic [8:0] y);
    logic [18:0] w;
    w = {10'd0, y};
    return {5'd0, (w << 9) + (w << 8) + (w << 5)};
  endfunction

endpackage

// File: rtl/plot_y_ram.sv
// Previous plotted row per column; registered read, write-through disabled.
// Read data reflects the address presented on the previous enabled edge.
module plot_y_ram
  import photon_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       we,
  input  logic [9:0] addr,
  input  logic [8:0] wdata,
  output logic [8:0] rdata
);

  logic [8:0] mem [HIST_LEN];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/pulse_plot_renderer.sv
// Renders the photon-counter history as a single-pixel trace in LCD GRAM.
// Per column: read history, erase the old pixel if it moved, draw the new one.
module pulse_plot_renderer
  import photon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iStart,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic [23:0] oSDRAM_Rd_Addr,
  input  logic [15:0] iSDRAM_Data,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  output logic [23:0] oSDRAM_Wr_Addr,
  output logic [15:0] oSDRAM_Wr_Data,
  output logic        oSDRAM_Wr_Req,
  input  logic        iSDRAM_Wr_Done
);

  state_e              state;
  logic [9:0]          col;
  logic                pending;
  logic [HIST_LEN-1:0] valid_q;
  logic [15:0]         data_q;
  logic [8:0]          y_q;
  logic [23:0]         draw_addr;
  logic                rd_req;
  logic                wr_req;

  logic [8:0]  prev_y;
  logic [15:0] v_full;
  logic [8:0]  v_clamp;
  logic [8:0]  y_c;
  logic [9:0]  x_c;
  logic [23:0] draw_c;
  logic [23:0] erase_c;
  logic        need_erase;
  logic        rd_fire;
  logic        wr_fire;

  plot_y_ram u_yram (
    .clk   (clk),
    .en    (en),
    .we    (en && state == S_NEXT),
    .addr  (col),
    .wdata (y_q),
    .rdata (prev_y)
  );

  always_comb begin
    v_full     = data_q >> Y_SHIFT;
    v_clamp    = (v_full > {7'd0, Y_MAX}) ? Y_MAX : v_full[8:0];
    y_c        = Y_MAX - v_clamp;
    x_c        = X_OFS + col;
    draw_c     = row_base(y_c) + {14'd0, x_c};
    erase_c    = row_base(prev_y) + {14'd0, x_c};
    need_erase = valid_q[col] && (prev_y != y_c);
  end

  assign rd_fire = rd_req && iSDRAM_Rd_Done;
  assign wr_fire = wr_req && iSDRAM_Wr_Done;

  // The completing cycle already shows the request low to the arbiter
  assign oSDRAM_Rd_Req = rd_req && !(en && iSDRAM_Rd_Done);
  assign oSDRAM_Wr_Req = wr_req && !(en && iSDRAM_Wr_Done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      col            <= '0;
      pending        <= 1'b0;
      valid_q        <= '0;
      data_q         <= '0;
      y_q            <= '0;
      draw_addr      <= '0;
      rd_req         <= 1'b0;
      wr_req         <= 1'b0;
      oBusy          <= 1'b0;
      oFrameDone     <= 1'b0;
      oSDRAM_Rd_Addr <= '0;
      oSDRAM_Wr_Addr <= '0;
      oSDRAM_Wr_Data <= '0;
    end else if (en) begin
      oFrameDone <= 1'b0;
      if (iStart && state != S_IDLE) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (iStart || pending) begin
            pending        <= 1'b0;
            oBusy          <= 1'b1;
            col            <= '0;
            oSDRAM_Rd_Addr <= HIST_BASE;
            rd_req         <= 1'b1;
            state          <= S_RD;
          end
        end
        S_RD: begin
          if (rd_fire) begin
            rd_req <= 1'b0;
            data_q <= iSDRAM_Data;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          y_q       <= y_c;
          draw_addr <= draw_c;
          wr_req    <= 1'b1;
          if (need_erase) begin
            oSDRAM_Wr_Addr <= erase_c;
            oSDRAM_Wr_Data <= BG_COLOR;
            state          <= S_ERASE;
          end else begin
            oSDRAM_Wr_Addr <= draw_c;
            oSDRAM_Wr_Data <= FG_COLOR;
            state          <= S_DRAW;
          end
        end
        S_ERASE: begin
          if (wr_fire) begin
            oSDRAM_Wr_Addr <= draw_addr;
            oSDRAM_Wr_Data <= FG_COLOR;
            state          <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (wr_fire) begin
            wr_req <= 1'b0;
            state  <= S_NEXT;
            if (col == LAST_COL) begin
              oBusy      <= 1'b0;
              oFrameDone <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          valid_q[col] <= 1'b1;
          if (col == LAST_COL) begin
            state <= S_DONE;
          end else begin
            col            <= col + 10'd1;
            oSDRAM_Rd_Addr <= HIST_BASE + {14'd0, col + 10'd1};
            rd_req         <= 1'b1;
            state          <= S_RD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_plot_renderer.sv
// Scoreboard bench for pulse_plot_renderer with an SDRAM responder model.
// Expected GRAM writes are queued at stimulus time and matched on completion.
module tb_pulse_plot_renderer;
  import photon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        iStart = 1'b0;
  logic        oBusy, oFrameDone;
  logic [23:0] oSDRAM_Rd_Addr, oSDRAM_Wr_Addr;
  logic [15:0] iSDRAM_Data = '0;
  logic [15:0] oSDRAM_Wr_Data;
  logic        oSDRAM_Rd_Req, oSDRAM_Wr_Req;
  logic        iSDRAM_Rd_Done = 1'b0;
  logic        iSDRAM_Wr_Done = 1'b0;

  pulse_plot_renderer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .iStart         (iStart),
    .oBusy          (oBusy),
    .oFrameDone     (oFrameDone),
    .oSDRAM_Rd_Addr (oSDRAM_Rd_Addr),
    .iSDRAM_Data    (iSDRAM_Data),
    .oSDRAM_Rd_Req  (oSDRAM_Rd_Req),
    .iSDRAM_Rd_Done (iSDRAM_Rd_Done),
    .oSDRAM_Wr_Addr (oSDRAM_Wr_Addr),
    .oSDRAM_Wr_Data (oSDRAM_Wr_Data),
    .oSDRAM_Wr_Req  (oSDRAM_Wr_Req),
    .iSDRAM_Wr_Done (iSDRAM_Wr_Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];

  int checks = 0;
  int failures = 0;
  int frames = 0;
  int erases = 0;
  int ovl = 0;
  int lat_max = 1;
  bit en_rand = 1'b0;

  logic [15:0] hist [HIST_LEN];
  int          mprev [HIST_LEN];
  bit          mvalid [HIST_LEN];

  task automatic chk(input string n, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", n, act, req, $time);
    end
  endtask

  function automatic void model_frame();
    for (int c = 0; c < HIST_LEN; c++) begin
      int v;
      int y;
      v = int'(hist[c] >> Y_SHIFT);
      if (v > 479) v = 479;
      y = 479 - v;
      if (mvalid[c] && mprev[c] != y)
        exp_q.push_back({24'(mprev[c] * 800 + 100 + c), BG_COLOR});
      exp_q.push_back({24'(y * 800 + 100 + c), FG_COLOR});
      mprev[c]  = y;
      mvalid[c] = 1'b1;
    end
  endfunction

  // SDRAM responder: owns en and both Done strobes
  initial begin
    int rc;
    int wc;
    int rl;
    int wl;
    int rcol;
    rc = 0; wc = 0; rl = 1; wl = 1; rcol = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        iSDRAM_Rd_Done = 1'b0;
        iSDRAM_Wr_Done = 1'b0;
        en = 1'b1;
        rc = 0; wc = 0; rcol = 0;
        continue;
      end
      if (oSDRAM_Rd_Req && oSDRAM_Wr_Req) ovl++;
      if (iSDRAM_Rd_Done || iSDRAM_Wr_Done) begin
        iSDRAM_Rd_Done = 1'b0;
        iSDRAM_Wr_Done = 1'b0;
        en = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        en = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (oSDRAM_Rd_Req) begin
          rc++;
          if (rc >= rl) begin
            chk("rd_addr", oSDRAM_Rd_Addr, HIST_BASE + 24'(rcol));
            iSDRAM_Data = hist[rcol];
            rcol = (rcol + 1) % HIST_LEN;
            en = 1'b1;
            iSDRAM_Rd_Done = 1'b1;
            rc = 0;
            rl = $urandom_range(1, lat_max);
          end
        end else if (oSDRAM_Wr_Req) begin
          wc++;
          if (wc >= wl) begin
            obs_q.push_back({oSDRAM_Wr_Addr, oSDRAM_Wr_Data});
            en = 1'b1;
            iSDRAM_Wr_Done = 1'b1;
            wc = 0;
            wl = $urandom_range(1, lat_max);
          end
        end
      end
    end
  end

  // Monitor: match completed writes against the expectation queue
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (obs_q.size() > 0) begin
        wr_t o;
        wr_t e;
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected got_addr=%0d got_data=%h", o.a, o.d);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", o.a, e.a);
          chk("wr_data", o.d, e.d);
        end
        if (o.d == BG_COLOR) erases++;
      end
      if (oFrameDone) frames++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_cnt", frames, target);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("busy_low", oBusy, 0);
  endtask

  initial begin
    int n;
    for (int c = 0; c < HIST_LEN; c++) begin
      hist[c] = '0;
      mvalid[c] = 1'b0;
      mprev[c] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", oBusy, 0);
    chk("rst_frame_done", oFrameDone, 0);
    chk("rst_rd_req", oSDRAM_Rd_Req, 0);
    chk("rst_wr_req", oSDRAM_Wr_Req, 0);
    chk("rst_rd_addr", oSDRAM_Rd_Addr, 0);
    chk("rst_wr_addr", oSDRAM_Wr_Addr, 0);
    chk("rst_wr_data", oSDRAM_Wr_Data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all zero history: bottom row everywhere, nothing to erase
    model_frame();
    chk("first_draw_addr", exp_q[0].a, 383300);
    erases = 0;
    pulse_start();
    wait_frames(1, 20000);
    chk("f1_erases", erases, 0);

    // entry 5 moves up by 10 rows
    hist[5] = 16'd10;
    model_frame();
    erases = 0;
    pulse_start();
    wait_frames(2, 20000);
    chk("f2_erases", erases, 1);

    // saturated counts clamp to the top row
    for (int c = 0; c < HIST_LEN; c++) hist[c] = 16'hFFFF;
    model_frame();
    erases = 0;
    pulse_start();
    wait_frames(3, 20000);
    chk("f3_erases", erases, 600);

    // three starts while busy collapse to one follow-up frame
    model_frame();
    model_frame();
    erases = 0;
    pulse_start();
    n = 0;
    while (!oBusy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_after_start", oBusy, 1);
    repeat (3) begin
      repeat (5) @(negedge clk);
      pulse_start();
    end
    wait_frames(5, 40000);
    repeat (100) @(negedge clk);
    chk("no_extra_frame", frames, 5);
    chk("multi_erases", erases, 0);

    // reset during the column-300 write
    for (int c = 0; c < HIST_LEN; c++) hist[c] = '0;
    model_frame();
    pulse_start();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(oSDRAM_Wr_Req && (int'(oSDRAM_Wr_Addr) % 800) == 400)
               && n < 20000);
    chk("reached_col300", oSDRAM_Wr_Req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_wr_req_drop", oSDRAM_Wr_Req, 0);
    chk("async_rd_req_drop", oSDRAM_Rd_Req, 0);
    chk("async_busy_drop", oBusy, 0);
    exp_q.delete();
    for (int c = 0; c < HIST_LEN; c++) mvalid[c] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    model_frame();
    erases = 0;
    pulse_start();
    wait_frames(6, 20000);
    chk("post_reset_erases", erases, 0);

    // random latencies with en toggling between completions
    for (int c = 0; c < HIST_LEN; c++) hist[c] = 16'($urandom_range(0, 1000));
    lat_max = 12;
    model_frame();
    pulse_start();
    en_rand = 1'b1;
    wait_frames(7, 60000);
    en_rand = 1'b0;
    chk("no_req_overlap", ovl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
